req_queue_2ch: RTL and testbench

REQ_QUEUE_2CH -- requirements
Module: req_queue_2ch

---
 rtl/req_queue_2ch_pkg.sv | 19 +
 rtl/req_queue_2ch_fifo.sv | 81 ++++++++
 rtl/req_queue_2ch.sv | 123 ++++++++++++
 tb/tb_req_queue_2ch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/req_queue_2ch_pkg.sv
// req_queue_2ch_pkg
//   Shared defaults and derived widths for the two-channel request queue.
//   Constants:
//     DATA_W_DEF - default payload width
//     DEPTH_DEF  - default entries per channel (power of two, >= 2)
//     PTR_W_DEF  - read/write pointer width for DEPTH_DEF
//     CNT_W_DEF  - occupancy count width for DEPTH_DEF (one extra bit so "full" fits)
//     CH0 / CH1  - channel index constants
package req_queue_2ch_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned PTR_W_DEF  = $clog2(DEPTH_DEF);
    localparam int unsigned CNT_W_DEF  = PTR_W_DEF + 1;

    localparam int unsigned CH0 = 0;
    localparam int unsigned CH1 = 1;

endpackage

// File: rtl/req_queue_2ch_fifo.sv
// sync_fifo_cnt
//   Single-clock FIFO with an explicit occupancy count.
//   Ports:
//     clk, rst   - clock, asynchronous active-high reset (pointers/count only)
//     push       - write push_data at the tail; ignored when full
//     push_data  - payload to write
//     pop        - advance the head; ignored when empty
//     head_data  - current head entry (valid when !empty)
//     count      - number of stored entries, 0..DEPTH
//     full/empty - count == DEPTH / count == 0
module sync_fifo_cnt
    import req_queue_2ch_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/req_queue_2ch.sv
// req_queue_2ch
//   Two independent request queues feeding a downstream 2-way arbiter.
//   Ports:
//     clk, rst            - clock, asynchronous active-high reset
//     in_valid[1:0]       - per-channel push request
//     in_data0, in_data1  - per-channel payload
//     in_ready[1:0]       - per-channel space available (registered state only)
//     req[1:0]            - request vector to the arbiter
//     gnt[1:0]            - registered one-hot grant from the arbiter
//     out_valid           - one-cycle beat following each valid pop
//     out_data, out_src   - payload and source channel of the last beat (held)
//     err_gnt             - sticky flag for illegal grants
module req_queue_2ch
    import req_queue_2ch_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        in_valid,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    output logic [1:0]        in_ready,
    output logic [1:0]        req,
    input  logic [1:0]        gnt,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              err_gnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] head0, head1;
    logic [CNT_W-1:0]  cnt0, cnt1;
    logic              full0, full1;
    logic              empty0, empty1;
    logic              gnt_bad;
    logic [1:0]        pop;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_src_q, out_src_d;
    logic              err_gnt_q, err_gnt_d;

    sync_fifo_cnt #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid[CH0]),
        .push_data (in_data0),
        .pop       (pop[CH0]),
        .head_data (head0),
        .count     (cnt0),
        .full      (full0),
        .empty     (empty0)
    );

    sync_fifo_cnt #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid[CH1]),
        .push_data (in_data1),
        .pop       (pop[CH1]),
        .head_data (head1),
        .count     (cnt1),
        .full      (full1),
        .empty     (empty1)
    );

    // Ready depends only on stored occupancy, never on this cycle's grant.
    assign in_ready = {~full1, ~full0};

    // A head granted this cycle is already leaving, so it is not requested again.
    assign req[CH0] = (cnt0 - CNT_W'(gnt[CH0])) != '0;
    assign req[CH1] = (cnt1 - CNT_W'(gnt[CH1])) != '0;

    // Any illegal grant suppresses both pops for that cycle.
    assign gnt_bad = (gnt == 2'b11)
                  || (gnt[CH0] && empty0)
                  || (gnt[CH1] && empty1);
    assign pop     = gnt_bad ? 2'b00 : gnt;

    always_comb begin
        out_valid_d = |pop;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        err_gnt_d   = err_gnt_q | gnt_bad;
        if (pop[CH0]) begin
            out_data_d = head0;
            out_src_d  = 1'(CH0);
        end else if (pop[CH1]) begin
            out_data_d = head1;
            out_src_d  = 1'(CH1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            err_gnt_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            err_gnt_q   <= err_gnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign err_gnt   = err_gnt_q;

endmodule

// File: tb/tb_req_queue_2ch.sv
// tb_req_queue_2ch
//   Directed bench for req_queue_2ch with a behavioural queue model and a
//   scoreboard of expected output beats.
module tb_req_queue_2ch;

    localparam int DW  = 8;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    in_valid;
    logic [DW-1:0] in_data0;
    logic [DW-1:0] in_data1;
    logic [1:0]    in_ready;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_src;
    logic          err_gnt;

    req_queue_2ch #(
        .DATA_W (DW),
        .DEPTH  (DEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .err_gnt   (err_gnt)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DW-1:0] m0[$];
    logic [DW-1:0] m1[$];
    logic [DW:0]   sb[$];
    logic          err_m;
    logic [DW-1:0] last_data;
    logic          last_src;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock with the currently driven inputs, update the model,
    // then check registered outputs just after the edge.
    task automatic cycle(input string tag);
        logic       beat;
        logic       r0, r1;
        logic [DW:0] it;
        beat = 1'b0;
        r0 = (m0.size() < DEP);
        r1 = (m1.size() < DEP);
        if (gnt == 2'b11 || (gnt[0] && m0.size() == 0) || (gnt[1] && m1.size() == 0)) begin
            err_m = 1'b1;
        end else if (gnt[0]) begin
            sb.push_back({1'b0, m0.pop_front()});
            beat = 1'b1;
        end else if (gnt[1]) begin
            sb.push_back({1'b1, m1.pop_front()});
            beat = 1'b1;
        end
        if (in_valid[0] && r0) m0.push_back(in_data0);
        if (in_valid[1] && r1) m1.push_back(in_data1);
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(beat));
        if (beat && sb.size() > 0) begin
            it        = sb.pop_front();
            last_src  = it[DW];
            last_data = it[DW-1:0];
        end
        chk({tag, ".out_data"}, 32'(out_data), 32'(last_data));
        chk({tag, ".out_src"}, 32'(out_src), 32'(last_src));
        chk({tag, ".err_gnt"}, 32'(err_gnt), 32'(err_m));
        chk({tag, ".in_ready"}, 32'(in_ready),
            32'({m1.size() < DEP, m0.size() < DEP}));
    endtask

    task automatic do_reset(input string tag);
        gnt      = 2'b00;
        in_valid = 2'b00;
        rst      = 1'b1;
        #1;
        chk({tag, ".rst_out_valid"}, 32'(out_valid), 32'(0));
        chk({tag, ".rst_out_data"}, 32'(out_data), 32'(0));
        chk({tag, ".rst_out_src"}, 32'(out_src), 32'(0));
        chk({tag, ".rst_err_gnt"}, 32'(err_gnt), 32'(0));
        chk({tag, ".rst_in_ready"}, 32'(in_ready), 32'(3));
        chk({tag, ".rst_req"}, 32'(req), 32'(0));
        m0.delete();
        m1.delete();
        sb.delete();
        err_m     = 1'b0;
        last_data = '0;
        last_src  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 2'b00;
        in_data0 = '0;
        in_data1 = '0;
        gnt      = 2'b00;
        #2;
        do_reset("init");

        // Two pushes on ch0, then two back-to-back grants.
        in_valid = 2'b01; in_data0 = 8'hA1; cycle("p0a");
        in_data0 = 8'hA2;                   cycle("p0b");
        in_valid = 2'b00; gnt = 2'b01;
        #1; chk("g1.req", 32'(req), 32'(1));
        cycle("g1");
        #1; chk("g2.req", 32'(req), 32'(0));
        cycle("g2");
        gnt = 2'b00; cycle("g_idle");

        // Fill ch1, then push+grant in the same cycle while full.
        in_valid = 2'b10;
        for (int i = 0; i < 4; i++) begin
            in_data1 = 8'hB0 + 8'(i);
            cycle("fill1");
        end
        in_data1 = 8'hB4; gnt = 2'b10;
        #1; chk("full_pg.in_ready", 32'(in_ready), 32'(1));
        cycle("full_pg");
        in_valid = 2'b00;
        for (int i = 0; i < 3; i++) cycle("drain1");
        gnt = 2'b00; cycle("drain1_idle");

        // Eight entries through ch0 across pointer wrap.
        in_valid = 2'b01;
        for (int i = 0; i < 8; i++) begin
            in_data0 = 8'h10 + 8'(i);
            gnt      = (i % 2 == 1) ? 2'b01 : 2'b00;
            cycle("wrap_push");
        end
        in_valid = 2'b00;
        for (int i = 0; i < 8 && m0.size() > 0; i++) begin
            gnt = 2'b01;
            cycle("wrap_drain");
        end
        gnt = 2'b00; cycle("wrap_idle");

        // One entry per channel, alternate grants.
        in_valid = 2'b11; in_data0 = 8'h00; in_data1 = 8'h01;
        cycle("both_push");
        in_valid = 2'b00;
        #1; chk("both.req11", 32'(req), 32'(3));
        gnt = 2'b01;
        #1; chk("both.req10", 32'(req), 32'(2));
        cycle("both_g0");
        gnt = 2'b10;
        #1; chk("both.req00", 32'(req), 32'(0));
        cycle("both_g1");
        gnt = 2'b00; cycle("both_idle");

        // Grant to an empty channel is an error and sticks.
        gnt = 2'b01; cycle("err_empty");
        gnt = 2'b00; cycle("err_hold1"); cycle("err_hold2");

        // Double grant with both channels occupied.
        do_reset("rst_b");
        in_valid = 2'b11; in_data0 = 8'h5A; in_data1 = 8'hA5;
        cycle("dbl_push");
        in_valid = 2'b00; gnt = 2'b11; cycle("dbl_gnt");
        gnt = 2'b00;
        #1; chk("dbl.req", 32'(req), 32'(3));
        cycle("dbl_hold");

        // Reset mid-operation with entries queued and a beat in flight.
        do_reset("rst_c");
        in_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            in_data0 = 8'hC0 + 8'(i);
            cycle("mid_push");
        end
        in_valid = 2'b00; gnt = 2'b01; cycle("mid_gnt");
        do_reset("rst_mid");
        for (int i = 0; i < 3; i++) begin
            #1; chk("post_rst.req", 32'(req), 32'(0));
            cycle("post_rst");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
